adc_frame_seq: RTL
==================

Name: adc_frame_seq

Overview:
Per-frame capture controller for the ADS131M08-class ADC. Each synchronized DRDY falling-edge pulse starts one SPI frame: a status word followed by NUM_CH channel words. The frame is issued one word at a time to an external SPI word engine. Each channel word goes downstream on a valid/ready sample stream. The block also keeps frame and overrun bookkeeping for CSR readback.

Parameters:
NUM_CH, 8, channel words per frame (1..15)
WORD_BITS, 24, bits per SPI word
CS_SETUP_CYC, 2, clk cycles from cs_n low to the first xfer_start (>=1)
CS_HOLD_CYC, 2, clk cycles from the last xfer_done to cs_n high (>=1)
OVR_W, 8, overrun counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new frames to start
drdy_pulse  in  1  single-cycle DRDY falling-edge pulse, already synchronized and armed
adc_cs_n  out  1  ADC chip select, active low
xfer_start  out  1  one-cycle request to the SPI engine for one word
xfer_tx  out  WORD_BITS  word to shift out; always 0 (NULL command)
xfer_done  in  1  one-cycle pulse when the word completes
xfer_rx  in  WORD_BITS  received word, valid when xfer_done=1
samp_valid  out  1  channel sample available
samp_ready  in  1  downstream accepts the sample
samp_ch  out  4  channel index 0..NUM_CH-1
samp_data  out  WORD_BITS  raw two's-complement sample
status_word  out  16  xfer_rx[23:8] of the most recent word 0
frame_cnt  out  32  number of completed frames, wraps modulo 2^32
frame_done  out  1  one-cycle pulse at the end of each frame
overrun  out  1  sticky flag: DRDY arrived while the block was busy
overrun_cnt  out  OVR_W  overrun count, saturating
overrun_clr  in  1  clears overrun and overrun_cnt
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream) forces:
  - state IDLE, adc_cs_n=1, xfer_start=0, samp_valid=0, frame_done=0;
  - samp_ch=0, samp_data=0, status_word=0, frame_cnt=0, overrun=0, overrun_cnt=0, word index=0.
- State machine:
  - IDLE: if drdy_pulse && enable, drive adc_cs_n=0 and go to SETUP with the delay counter set to CS_SETUP_CYC-1.
  - SETUP: count down; at 0, pulse xfer_start and go to WAIT.
  - WAIT: hold until xfer_done.
    - Word 0: latch status_word, then go to ISSUE.
    - Word k>=1: load samp_data=xfer_rx and samp_ch=k-1, assert samp_valid, go to PUSH.
  - PUSH: hold samp_valid, samp_ch and samp_data stable until samp_ready. On the handshake, drop samp_valid. If k==NUM_CH go to HOLD, else go to ISSUE.
  - ISSUE: pulse xfer_start, increment the word index, go to WAIT.
  - HOLD: count CS_HOLD_CYC cycles. On exit: adc_cs_n=1, frame_done pulse, frame_cnt+1, back to IDLE.
- Latency: drdy_pulse in cycle T gives adc_cs_n low at T+1 and the first xfer_start at T+1+CS_SETUP_CYC.
- xfer_start is never asserted while a word is outstanding. Exactly NUM_CH+1 xfer_start pulses occur per frame.
- Backpressure: samp_ready low stalls the frame; SPI clocks stop and cs_n stays low. This is legal because this block is SPI master.
- Overrun:
  - drdy_pulse in any state other than IDLE sets overrun and increments overrun_cnt, saturating at all-ones.
  - The pulse is dropped; no frame is queued.
  - This includes the HOLD exit cycle.
  - overrun_clr in the same cycle as an overrun event: the clear wins.
- drdy_pulse in IDLE while enable=0: ignored, not counted as an overrun.
- enable deasserted mid-frame: the current frame completes normally, keeping ADC word alignment; no new frame starts.
- xfer_done is ignored outside WAIT.
- Reset mid-frame: outputs return to their reset values immediately and adc_cs_n goes high asynchronously.

Decomposition:
- adc_pkg holds:
  - state encoding localparams (IDLE, SETUP, ISSUE, WAIT, PUSH, HOLD);
  - ADC_NULL_CMD = 24'h000000;
  - ADC_WORD_BITS = 24;
  - ADC_NUM_CH = 8.
- Single module, no sub-module. The SPI shifter is the existing separate word engine; the DRDY synchronizer sits upstream.

Test Plan:
1. Single frame, samp_ready tied 1, CS_SETUP/HOLD=2: drdy_pulse at cycle 10; responder returns status 24'hA5C300 then channels 24'h000001..24'h000008.
   - adc_cs_n falls at cycle 11 and the first xfer_start is at cycle 13.
   - status_word=16'hA5C3; 8 samples ch0..7 with data 1..8; 9 xfer_starts total.
   - frame_done pulses once; frame_cnt=1.
2. Backpressure: samp_ready low for 20 cycles on ch3.
   - samp_valid, samp_ch=3 and samp_data stay stable throughout.
   - No xfer_start while stalled; the frame then completes with all 8 samples in order.
3. Overrun: second drdy_pulse during WAIT of word 4, another during the HOLD exit cycle.
   - overrun=1 and overrun_cnt=2; the current frame is unaffected; frame_cnt=1.
   - overrun_clr returns the count to 0; clear coincident with an event leaves it at 0.
4. Saturation: 300 busy-time DRDY pulses with OVR_W=8 -> overrun_cnt=255.
5. Enable handling:
   - enable dropped after word 2 -> the frame still finishes, frame_cnt increments, and a later drdy_pulse starts nothing and counts no overrun.
   - enable re-raised -> the next pulse starts a frame.
6. Reset mid-frame: rst_n low during PUSH.
   - adc_cs_n=1 and samp_valid=0 in the same cycle, with all counters at 0.
   - After release, a fresh drdy_pulse runs a clean full frame.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and state encoding for the ADC frame sequencer
package adc_pkg;

    localparam int          ADC_WORD_BITS = 24;
    localparam int          ADC_NUM_CH    = 8;
    localparam logic [23:0] ADC_NULL_CMD  = 24'h000000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_PUSH  = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

endpackage

// File: rtl/adc_frame_seq.sv
// rtl/adc_frame_seq.sv - per-DRDY SPI frame sequencer with sample stream and overrun bookkeeping
module adc_frame_seq
    import adc_pkg::*;
#(
    parameter int NUM_CH       = ADC_NUM_CH,
    parameter int WORD_BITS    = ADC_WORD_BITS,
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2,
    parameter int OVR_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 drdy_pulse,
    output logic                 adc_cs_n,
    output logic                 xfer_start,
    output logic [WORD_BITS-1:0] xfer_tx,
    input  logic                 xfer_done,
    input  logic [WORD_BITS-1:0] xfer_rx,
    output logic                 samp_valid,
    input  logic                 samp_ready,
    output logic [3:0]           samp_ch,
    output logic [WORD_BITS-1:0] samp_data,
    output logic [15:0]          status_word,
    output logic [31:0]          frame_cnt,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [OVR_W-1:0]     overrun_cnt,
    input  logic                 overrun_clr,
    output logic                 busy
);

    // One down-counter serves both the cs setup and the cs hold phases.
    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_widx;
    logic                 r_cs_n;
    logic                 r_xfer_start;
    logic                 r_samp_valid;
    logic [3:0]           r_samp_ch;
    logic [WORD_BITS-1:0] r_samp_data;
    logic [15:0]          r_status;
    logic [31:0]          r_frame_cnt;
    logic                 r_frame_done;
    logic                 r_overrun;
    logic [OVR_W-1:0]     r_ovr_cnt;

    logic                 w_busy;
    logic                 w_ovr_event;

    assign w_busy      = (r_state != ST_IDLE);
    // A DRDY that lands while a frame is in flight is dropped, never queued.
    assign w_ovr_event = drdy_pulse && w_busy;

    // Frame sequencing: cs setup, one word at a time, sample hand-off, cs hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_widx       <= '0;
            r_cs_n       <= 1'b1;
            r_xfer_start <= 1'b0;
            r_samp_valid <= 1'b0;
            r_samp_ch    <= '0;
            r_samp_data  <= '0;
            r_status     <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_xfer_start <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (drdy_pulse && enable) begin
                        r_cs_n  <= 1'b0;
                        r_cnt   <= CNT_W'(CS_SETUP_CYC - 1);
                        r_widx  <= '0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_xfer_start <= 1'b1;
                        r_state      <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (xfer_done) begin
                        if (r_widx == 4'd0) begin
                            r_status <= xfer_rx[WORD_BITS-1 -: 16];
                            r_state  <= ST_ISSUE;
                        end else begin
                            r_samp_data  <= xfer_rx;
                            r_samp_ch    <= r_widx - 4'd1;
                            r_samp_valid <= 1'b1;
                            r_state      <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    // Backpressure simply parks here; as SPI master we can stall the ADC.
                    if (samp_ready) begin
                        r_samp_valid <= 1'b0;
                        if (r_widx == 4'(NUM_CH)) begin
                            r_cnt   <= CNT_W'(CS_HOLD_CYC - 1);
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_xfer_start <= 1'b1;
                    r_widx       <= r_widx + 4'd1;
                    r_state      <= ST_WAIT;
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_cs_n       <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 32'd1;
                        r_widx       <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_cs_n  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Overrun bookkeeping; a coincident clear takes priority over a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_ovr_event) begin
            r_overrun <= 1'b1;
            if (r_ovr_cnt != {OVR_W{1'b1}}) begin
                r_ovr_cnt <= r_ovr_cnt + OVR_W'(1);
            end
        end
    end

    assign adc_cs_n    = r_cs_n;
    assign xfer_start  = r_xfer_start;
    assign xfer_tx     = WORD_BITS'(ADC_NULL_CMD);
    assign samp_valid  = r_samp_valid;
    assign samp_ch     = r_samp_ch;
    assign samp_data   = r_samp_data;
    assign status_word = r_status;
    assign frame_cnt   = r_frame_cnt;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovr_cnt;
    assign busy        = w_busy;

endmodule
